// File: rtl/pipe_reg_chain.sv
// Parametrised pipeline register chain: WIDTH-bit payload plus valid through DEPTH stages,
// with per-stage stall (upstream back-pressure), per-stage flush and bubble insertion.

module pipe_reg_stage #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             hold_i,
   input  logic             up_hold_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;

   // Flush beats hold; a free stage behind a frozen upstream takes a bubble.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (flush_i) begin
         data_d  = BUBBLE_VAL;
         valid_d = 1'b0;
      end else if (hold_i) begin
         data_d  = data_q;
         valid_d = valid_q;
      end else if (up_hold_i) begin
         data_d  = BUBBLE_VAL;
         valid_d = 1'b0;
      end else begin
         data_d  = data_i;
         valid_d = valid_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= RESET_VAL;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

module pipe_reg_chain #(
   parameter int               WIDTH      = 32,
   parameter int               DEPTH      = 3,
   parameter logic [WIDTH-1:0] RESET_VAL  = '0,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   in_ready,
   input  logic [DEPTH-1:0]       stall,
   input  logic [DEPTH-1:0]       flush,
   output logic [DEPTH*WIDTH-1:0] stage_data,
   output logic [DEPTH-1:0]       stage_valid,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_valid
);

   // Index 0 is the chain input; index i+1 is the register of stage i.
   logic [DEPTH:0][WIDTH-1:0] dat_pipe;
   logic [DEPTH:0]            vld_pipe;
   logic [DEPTH-1:0]          hold;

   assign dat_pipe[0] = in_data;
   assign vld_pipe[0] = in_valid;

   genvar i;
   for (i = 0; i < DEPTH; i++) begin : g_stage
      logic up_hold;

      // A stall anywhere downstream freezes this stage too.
      assign hold[i] = |stall[DEPTH-1:i];

      if (i == 0) begin : g_head
         assign up_hold = 1'b0;
      end else begin : g_body
         assign up_hold = hold[i-1];
      end

      pipe_reg_stage #(
         .WIDTH      (WIDTH),
         .RESET_VAL  (RESET_VAL),
         .BUBBLE_VAL (BUBBLE_VAL)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .flush_i   (flush[i]),
         .hold_i    (hold[i]),
         .up_hold_i (up_hold),
         .data_i    (dat_pipe[i]),
         .valid_i   (vld_pipe[i]),
         .data_o    (dat_pipe[i+1]),
         .valid_o   (vld_pipe[i+1])
      );
   end

   assign in_ready    = ~hold[0];
   assign stage_data  = dat_pipe[DEPTH:1];
   assign stage_valid = vld_pipe[DEPTH:1];
   assign out_data    = dat_pipe[DEPTH];
   assign out_valid   = vld_pipe[DEPTH];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: scoreboard streaming, table-driven stall/flush vectors,
// async reset corner and a DEPTH=1 instance.

module tb_pipe_reg_chain;

   localparam int          W   = 32;
   localparam logic [31:0] BUB = 32'hBBBB_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // DEPTH=3 instance
   logic          iv3 = 1'b0;
   logic [W-1:0]  d3 = '0;
   logic          rdy3;
   logic [2:0]    st3 = '0, fl3 = '0;
   logic [3*W-1:0] sd3;
   logic [2:0]    sv3;
   logic [W-1:0]  od3;
   logic          ov3;

   // DEPTH=1 instance
   logic          iv1 = 1'b0;
   logic [W-1:0]  d1 = '0;
   logic          rdy1;
   logic [0:0]    st1 = '0, fl1 = '0;
   logic [W-1:0]  sd1;
   logic [0:0]    sv1;
   logic [W-1:0]  od1;
   logic          ov1;

   pipe_reg_chain #(.WIDTH(W), .DEPTH(3), .RESET_VAL(32'h0), .BUBBLE_VAL(BUB)) u3 (
      .clk(clk), .rst(rst), .in_valid(iv3), .in_data(d3), .in_ready(rdy3),
      .stall(st3), .flush(fl3), .stage_data(sd3), .stage_valid(sv3),
      .out_data(od3), .out_valid(ov3)
   );

   pipe_reg_chain #(.WIDTH(W), .DEPTH(1), .RESET_VAL(32'h0), .BUBBLE_VAL(BUB)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_data(d1), .in_ready(rdy1),
      .stall(st1), .flush(fl1), .stage_data(sd1), .stage_valid(sv1),
      .out_data(od1), .out_valid(ov1)
   );

   int npass = 0;
   int ntot  = 0;
   int ecnt  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      ecnt++;
      #1;
   endtask

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic [2:0]  st;
      logic [2:0]  fl;
      logic        rdy;
      logic [2:0]  vld;
      logic [31:0] s0, s1, s2;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      int          due;
   } sb_t;

   vec_t tbl[14];
   sb_t  sbq[$];

   initial begin
      //          iv    d      st      fl     rdy  vld     s0     s1     s2
      tbl[0]  = '{1'b1, 32'h00, 3'b000, 3'b000, 1'b1, 3'b001, 32'h00, 32'h00, 32'h00};
      tbl[1]  = '{1'b1, 32'h04, 3'b000, 3'b000, 1'b1, 3'b011, 32'h04, 32'h00, 32'h00};
      tbl[2]  = '{1'b1, 32'h08, 3'b000, 3'b000, 1'b1, 3'b111, 32'h08, 32'h04, 32'h00};
      tbl[3]  = '{1'b1, 32'h0C, 3'b010, 3'b000, 1'b0, 3'b011, 32'h08, 32'h04, BUB};
      tbl[4]  = '{1'b1, 32'h0C, 3'b000, 3'b000, 1'b1, 3'b111, 32'h0C, 32'h08, 32'h04};
      tbl[5]  = '{1'b1, 32'h10, 3'b000, 3'b011, 1'b1, 3'b100, BUB,    BUB,    32'h08};
      tbl[6]  = '{1'b1, 32'h14, 3'b000, 3'b000, 1'b1, 3'b001, 32'h14, BUB,    BUB};
      tbl[7]  = '{1'b1, 32'h18, 3'b000, 3'b000, 1'b1, 3'b011, 32'h18, 32'h14, BUB};
      tbl[8]  = '{1'b1, 32'h1C, 3'b000, 3'b000, 1'b1, 3'b111, 32'h1C, 32'h18, 32'h14};
      tbl[9]  = '{1'b1, 32'h20, 3'b010, 3'b010, 1'b0, 3'b001, 32'h1C, BUB,    BUB};
      tbl[10] = '{1'b1, 32'h20, 3'b100, 3'b000, 1'b0, 3'b001, 32'h1C, BUB,    BUB};
      tbl[11] = '{1'b0, 32'h20, 3'b000, 3'b000, 1'b1, 3'b010, 32'h20, 32'h1C, BUB};
      tbl[12] = '{1'b0, 32'h24, 3'b000, 3'b000, 1'b1, 3'b100, 32'h24, 32'h20, 32'h1C};
      tbl[13] = '{1'b0, 32'h28, 3'b000, 3'b100, 1'b1, 3'b000, 32'h28, 32'h24, BUB};

      // Reset state, with live-looking input present.
      iv3 = 1'b1; d3 = 32'h55;
      step(); step();
      chk("rst_valid", 64'(sv3), 64'h0);
      chk("rst_out_data", 64'(od3), 64'h0);
      chk("rst_out_valid", 64'(ov3), 64'h0);
      chk("rst_in_ready", 64'(rdy3), 64'h1);
      chk("rst_d1_valid", 64'(ov1), 64'h0);
      #2 rst = 1'b0;
      #1 chk("rst_release_hold", 64'(sv3), 64'h0);

      // Streaming through the scoreboard.
      for (int k = 0; k < 12 && (k < 5 || sbq.size() != 0); k++) begin
         if (k < 5) begin
            iv3 = 1'b1; d3 = 32'(4 * k);
            sbq.push_back('{32'(4 * k), ecnt + 3});
         end else begin
            iv3 = 1'b0; d3 = 32'h99;
         end
         #1 chk("stream_ready", 64'(rdy3), 64'h1);
         step();
         if (sbq.size() != 0 && sbq[0].due == ecnt) begin
            chk("stream_out_valid", 64'(ov3), 64'h1);
            chk("stream_out_data", 64'(od3), 64'(sbq[0].d));
            void'(sbq.pop_front());
         end else begin
            chk("stream_no_out", 64'(ov3), 64'h0);
         end
      end
      chk("stream_drained", 64'(sbq.size()), 64'h0);

      // Load something, then reset asynchronously mid-cycle.
      iv3 = 1'b1; d3 = 32'h30;
      step();
      chk("pre_rst_valid", 64'(sv3[0]), 64'h1);
      #2 rst = 1'b1;
      #1 chk("async_rst_valid", 64'(sv3), 64'h0);
      chk("async_rst_data", 64'(sd3), 64'h0);
      step();
      #2 rst = 1'b0;
      #1 chk("async_rel_valid", 64'(sv3), 64'h0);

      // Table-driven stall/flush vectors.
      for (int r = 0; r < 14; r++) begin
         iv3 = tbl[r].iv; d3 = tbl[r].d; st3 = tbl[r].st; fl3 = tbl[r].fl;
         #1 chk($sformatf("tbl%0d_ready", r), 64'(rdy3), 64'(tbl[r].rdy));
         step();
         chk($sformatf("tbl%0d_valid", r), 64'(sv3), 64'(tbl[r].vld));
         chk($sformatf("tbl%0d_s0", r), 64'(sd3[0*W +: W]), 64'(tbl[r].s0));
         chk($sformatf("tbl%0d_s1", r), 64'(sd3[1*W +: W]), 64'(tbl[r].s1));
         chk($sformatf("tbl%0d_s2", r), 64'(sd3[2*W +: W]), 64'(tbl[r].s2));
         chk($sformatf("tbl%0d_out", r), 64'({ov3, od3}), 64'({tbl[r].vld[2], tbl[r].s2}));
      end
      st3 = '0; fl3 = '0; iv3 = 1'b0;

      // DEPTH=1 corner cases.
      iv1 = 1'b1; d1 = 32'h100;
      #1 chk("d1_ready", 64'(rdy1), 64'h1);
      step();
      chk("d1_capture", 64'({ov1, od1}), {31'h0, 1'b1, 32'h100});
      d1 = 32'h104; st1 = 1'b1;
      #1 chk("d1_stall_ready", 64'(rdy1), 64'h0);
      step();
      chk("d1_stall_hold", 64'({ov1, od1}), {31'h0, 1'b1, 32'h100});
      fl1 = 1'b1;
      step();
      chk("d1_flush", 64'({ov1, od1}), {31'h0, 1'b0, BUB});
      chk("d1_stage_data", 64'(sd1), 64'(BUB));
      st1 = 1'b0; fl1 = 1'b0; d1 = 32'h108;
      step();
      chk("d1_resume", 64'({sv1, od1}), {31'h0, 1'b1, 32'h108});

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
